mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Program loader that sits directly upstream of the 64 KiB synchronous system RAM.
- Takes a framed byte stream on a valid/ready interface, for example from a UART receiver. Writes each payload into RAM through the RAM's single write port.
- Holds the 6502 in reset until a run command arrives.
- While CpuHold is high, the top-level address/data/WE mux gives RAM ownership to this block. After that, the CPU owns the RAM.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes inside a packet before the packet is aborted.
- SYNC_LOAD, 8'h55: header byte that starts a load packet.
- SYNC_RUN, 8'hAA: header byte that releases the CPU.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RxData  in  8  incoming stream byte.
- RxValid  in  1  RxData is valid.
- RxReady  out  1  loader accepts a byte. A byte transfers on a rising edge where RxValid and RxReady are both high.
- MemWE  out  1  RAM write enable, one-cycle pulse per payload byte.
- MemAddress  out  16  RAM address.
- MemData  out  8  RAM write data.
- CpuHold  out  1  high keeps the CPU in reset and gives RAM ownership to the loader.
- LoadDone  out  1  one-cycle pulse when a packet passes its checksum.
- LoadError  out  1  sticky error flag; cleared when the next SYNC_LOAD is accepted, or by RST.

Behaviour:
- Reset values: state=IDLE, RxReady=1, MemWE=0, MemAddress=0, MemData=0, CpuHold=1, LoadDone=0, LoadError=0, checksum=0, timeout counter=0.
- Packet format: SYNC_LOAD, ADDR_HI, ADDR_LO, LEN, then payload bytes, then CHK.
  - LEN=0 means 256 payload bytes; LEN=n (1..255) means n bytes.
- Checksum: 8-bit modular sum of ADDR_HI+ADDR_LO+LEN+all payload bytes+CHK. The packet is valid when this sum equals 8'h00.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CHK, RUN. Transitions happen only on an accepted byte, except for timeout.
  - IDLE:
    - SYNC_LOAD → ADDR_HI; clear checksum; clear LoadError.
    - SYNC_RUN → RUN.
    - Any other byte is discarded; stay in IDLE.
  - ADDR_HI → ADDR_LO → LEN: latch the bytes into the base address; add each to the checksum.
  - LEN → DATA: load the remaining count (0 loads 256, so the counter is 9 bits).
  - DATA: on each accepted byte:
    - register MemAddress=current pointer, MemData=byte, MemWE=1 for the following cycle only;
    - increment the pointer modulo 2^16 (FFFF wraps to 0000);
    - decrement the count and add the byte to the checksum;
    - go to CHK when the count reaches 0.
  - CHK:
    - sum==0 → LoadDone=1 for one cycle, go to IDLE.
    - otherwise → LoadError=1, go to IDLE.
  - RUN:
    - CpuHold=0 and RxReady=0.
    - MemWE held at 0.
    - Remain in RUN until RST.
- Write latency: a byte accepted at edge N produces MemWE=1 during the cycle after edge N, with matching address and data. Back-to-back bytes produce back-to-back write pulses.
- Payload bytes are committed as they arrive. A checksum failure or abort does not undo writes already made; it only sets LoadError.
- Timeout:
  - In ADDR_HI, ADDR_LO, LEN, DATA and CHK, the counter increments on every cycle without an accepted byte and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES: set LoadError, go to IDLE, clear the counter. No write occurs in that cycle.
  - The counter is held at 0 in IDLE and RUN.
- SYNC_LOAD or SYNC_RUN values received mid-packet are treated as ordinary data. There is no resync.
- CpuHold changes only on entry to RUN or on RST.
- RxReady is high in every state except RUN. No backpressure is generated while loading.
- RST asserted mid-packet or in RUN: all outputs return to reset values on the next edge. An in-flight MemWE pulse is suppressed.
- LoadDone and LoadError can never rise in the same cycle.

Test Plan:
- Stream 55 03 00 02 A2 07 52 → writes $0300=A2, $0301=07 on consecutive cycles, each one cycle after acceptance; LoadDone pulses once; LoadError=0; CpuHold=1.
- Stream 55 FF FF 02 11 22 then a bad CHK 00 → writes $FFFF=11 and $0000=22 (address wrap); LoadError=1; no LoadDone; next 55 clears LoadError.
- Stream 55 10 00 00, then 256 bytes 00..FF, then the correct CHK (so the total sum is 0) → exactly 256 MemWE pulses at $1000..$10FF; LoadDone=1.
- With TIMEOUT_CYCLES=16, stream 55 02 00 then stall 16 cycles → LoadError=1, state back to IDLE; a following 33 is ignored; then a valid packet loads normally.
- Load a valid packet, then stream AA → CpuHold drops the cycle after acceptance; RxReady=0; further RxValid produces no MemWE. Assert RST → CpuHold=1, RxReady=1.
- Stream 77 then 55 00 80 01 ... with RST pulsed after the first payload byte's acceptance edge → that byte's MemWE is suppressed; all outputs at reset values; the garbage byte 77 in IDLE causes no state change.

Source files
------------

// File: rtl/mem_loader.sv
// Framed-stream program loader: writes payloads into system RAM and holds the
// 6502 in reset until a run command arrives.
module mem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_LOAD      = 8'h55,
    parameter logic [7:0]  SYNC_RUN       = 8'hAA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        MemWE,
    output logic [15:0] MemAddress,
    output logic [7:0]  MemData,
    output logic        CpuHold,
    output logic        LoadDone,
    output logic        LoadError
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CHK, RUN
    } state_t;

    state_t        state, next_state;
    logic          accept, busy, timeout;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    checksum, chk_sum;
    logic [8:0]    count;
    logic [15:0]   ptr;

    assign accept  = RxValid && RxReady;
    assign busy    = (state != IDLE) && (state != RUN);
    assign chk_sum = checksum + RxData;
    // Abort on the edge that would bring the idle count up to TIMEOUT_CYCLES.
    assign timeout = busy && !accept && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (RxData == SYNC_LOAD)     next_state = ADDR_HI;
                    else if (RxData == SYNC_RUN) next_state = RUN;
                end
                ADDR_HI: next_state = ADDR_LO;
                ADDR_LO: next_state = LEN;
                LEN:     next_state = DATA;
                DATA:    if (count == 9'd1) next_state = CHK;
                CHK:     next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        RxReady = (state != RUN);
        CpuHold = (state != RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MemWE      <= 1'b0;
            MemAddress <= '0;
            MemData    <= '0;
            LoadDone   <= 1'b0;
            LoadError  <= 1'b0;
            checksum   <= '0;
            count      <= '0;
            ptr        <= '0;
            idle_cnt   <= '0;
        end else begin
            MemWE    <= 1'b0;
            LoadDone <= 1'b0;
            if (busy && !accept && !timeout) idle_cnt <= idle_cnt + CW'(1);
            else                             idle_cnt <= '0;
            if (timeout) LoadError <= 1'b1;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (RxData == SYNC_LOAD) begin
                            checksum  <= '0;
                            LoadError <= 1'b0;
                        end
                    end
                    ADDR_HI: begin
                        ptr[15:8] <= RxData;
                        checksum  <= chk_sum;
                    end
                    ADDR_LO: begin
                        ptr[7:0] <= RxData;
                        checksum <= chk_sum;
                    end
                    LEN: begin
                        count    <= (RxData == 8'd0) ? 9'd256 : {1'b0, RxData};
                        checksum <= chk_sum;
                    end
                    DATA: begin
                        MemWE      <= 1'b1;
                        MemAddress <= ptr;
                        MemData    <= RxData;
                        ptr        <= ptr + 16'd1;
                        count      <= count - 9'd1;
                        checksum   <= chk_sum;
                    end
                    CHK: begin
                        if (chk_sum == 8'd0) LoadDone  <= 1'b1;
                        else                 LoadError <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader (timeout shortened to 16 cycles).
module tb_mem_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MemWE;
    logic [15:0] MemAddress;
    logic [7:0]  MemData;
    logic        CpuHold;
    logic        LoadDone;
    logic        LoadError;

    int passes = 0;
    int total  = 0;
    int we_count = 0;
    int bulk_bad = 0;
    bit bulk_phase = 1'b0;
    int base;

    mem_loader #(.TIMEOUT_CYCLES(16), .SYNC_LOAD(8'h55), .SYNC_RUN(8'hAA)) dut (
        .CLK(CLK), .RST(RST), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .MemWE(MemWE), .MemAddress(MemAddress),
        .MemData(MemData), .CpuHold(CpuHold), .LoadDone(LoadDone),
        .LoadError(LoadError)
    );

    always #5 CLK = ~CLK;

    // Write-pulse monitor; during the 256-byte load each write must carry data == low address byte.
    always @(negedge CLK) begin
        if (MemWE === 1'b1) begin
            we_count++;
            if (bulk_phase && (MemAddress[15:8] !== 8'h10 || MemData !== MemAddress[7:0]))
                bulk_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        RxData  = b;
        RxValid = 1'b1;
        @(posedge CLK);
        #1;
        RxValid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  RxReady,    1);
        check({tag, "_we"},   MemWE,      0);
        check({tag, "_addr"}, MemAddress, 0);
        check({tag, "_data"}, MemData,    0);
        check({tag, "_hold"}, CpuHold,    1);
        check({tag, "_done"}, LoadDone,   0);
        check({tag, "_err"},  LoadError,  0);
    endtask

    initial begin
        RST = 1'b1; RxValid = 1'b0; RxData = 8'h00;
        tick(2);
        check_reset_outputs("reset");
        @(negedge CLK); RST = 1'b0;

        // Basic two-byte load at $0300
        send(8'h55); send(8'h03); send(8'h00); send(8'h02);
        send(8'hA2);
        check("t1_we0", MemWE, 1); check("t1_addr0", MemAddress, 16'h0300); check("t1_data0", MemData, 8'hA2);
        send(8'h07);
        check("t1_we1", MemWE, 1); check("t1_addr1", MemAddress, 16'h0301); check("t1_data1", MemData, 8'h07);
        send(8'h52);
        check("t1_we_off", MemWE, 0);
        check("t1_done", LoadDone, 1); check("t1_err", LoadError, 0); check("t1_hold", CpuHold, 1);
        tick(1);
        check("t1_done_pulse", LoadDone, 0);

        // Address wrap and bad checksum
        send(8'h55); send(8'hFF); send(8'hFF); send(8'h02);
        send(8'h11);
        check("t2_addr0", MemAddress, 16'hFFFF); check("t2_data0", MemData, 8'h11);
        send(8'h22);
        check("t2_we1", MemWE, 1); check("t2_addr1", MemAddress, 16'h0000); check("t2_data1", MemData, 8'h22);
        send(8'h00);
        check("t2_err", LoadError, 1); check("t2_nodone", LoadDone, 0);
        tick(3);
        check("t2_err_sticky", LoadError, 1);
        send(8'h55);
        check("t2_err_clr", LoadError, 0);

        // Timeout: already past 55, send 02 00 then stall
        send(8'h02); send(8'h00);
        tick(10);
        check("t4_no_early_to", LoadError, 0);
        tick(10);
        check("t4_timeout_err", LoadError, 1);
        base = we_count;
        send(8'h33);
        tick(2);
        check("t4_ignored_we", we_count - base, 0);
        check("t4_err_kept", LoadError, 1);
        send(8'h55);
        check("t4_err_clr", LoadError, 0);
        send(8'h20); send(8'h00); send(8'h01); send(8'h5A);
        check("t4_addr", MemAddress, 16'h2000); check("t4_data", MemData, 8'h5A);
        send(8'h85);
        check("t4_done", LoadDone, 1); check("t4_err", LoadError, 0);

        // 256-byte payload (LEN=0)
        base = we_count;
        send(8'h55); send(8'h10); send(8'h00); send(8'h00);
        bulk_phase = 1'b1;
        for (int i = 0; i < 256; i++) send(8'(i));
        check("t3_last_addr", MemAddress, 16'h10FF);
        send(8'h70);
        tick(1);
        bulk_phase = 1'b0;
        check("t3_we_count", we_count - base, 256);
        check("t3_bad_writes", bulk_bad, 0);
        check("t3_err", LoadError, 0);

        // Successful packet followed by run command
        send(8'h55); send(8'h03); send(8'h00); send(8'h02); send(8'hA2); send(8'h07); send(8'h52);
        check("t5_done", LoadDone, 1);
        send(8'hAA);
        check("t5_hold", CpuHold, 0); check("t5_rdy", RxReady, 0);
        base = we_count;
        @(negedge CLK); RxData = 8'h55; RxValid = 1'b1;
        tick(4);
        RxValid = 1'b0;
        check("t5_no_we", we_count - base, 0);
        check("t5_hold_kept", CpuHold, 0);
        @(negedge CLK); RST = 1'b1;
        tick(1);
        check("t5_rst_hold", CpuHold, 1); check("t5_rst_rdy", RxReady, 1);
        @(negedge CLK); RST = 1'b0;

        // Garbage in IDLE, then reset coinciding with first payload byte
        base = we_count;
        send(8'h77);
        check("t6_garbage_err", LoadError, 0);
        send(8'h55); send(8'h00); send(8'h80); send(8'h01);
        @(negedge CLK); RxData = 8'hC3; RxValid = 1'b1; RST = 1'b1;
        tick(1);
        RxValid = 1'b0;
        check("t6_no_we", we_count - base, 0);
        check_reset_outputs("t6_rst");
        @(negedge CLK); RST = 1'b0;
        send(8'h55); send(8'h00); send(8'h80); send(8'h01); send(8'hC3);
        check("t6_addr", MemAddress, 16'h0080); check("t6_data", MemData, 8'hC3);
        send(8'hBC);
        check("t6_done", LoadDone, 1);
        check("t6_we_total", we_count - base, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
